// File: rtl/aes_key_expander.sv
// aes_key_expander: sequential AES-128 key schedule producing one word per cycle into an 11-round-key register file
module aes_key_expander (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         key_ready,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic {IDLE, EXPAND} state_t;
  state_t      state, state_nx;
  logic [31:0] w [0:43];
  logic [5:0]  i;
  logic [7:0]  rcon;
  logic [31:0] prev, rot, t;
  logic [3:0]  rr;
  logic [5:0]  base;
  logic        accept, last;
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  assign accept = (state == IDLE) && start;
  assign last   = (state == EXPAND) && (i == 6'd43);
  assign prev   = w[i - 6'd1];
  assign rot    = {prev[23:0], prev[31:24]};
  assign t      = (i[1:0] == 2'b00) ? {sb(rot[31:24]) ^ rcon, sb(rot[23:16]), sb(rot[15:8]), sb(rot[7:0])} : prev;
  assign rr     = (rd_round > 4'd10) ? 4'd0 : rd_round;
  assign base   = {rr, 2'b00};
  assign rd_key = (rd_round > 4'd10) ? 128'h0 : {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: accept a key in IDLE, return to IDLE once w43 is written
  always_comb state_nx = accept ? EXPAND : last ? IDLE : state;
  // outputs decoded from state
  always_comb busy = (state == EXPAND);
  // word storage, counter, round constant and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 44; k++) w[k] <= '0;
      i         <= '0;
      rcon      <= 8'h01;
      done      <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        w[0]      <= key[127:96];
        w[1]      <= key[95:64];
        w[2]      <= key[63:32];
        w[3]      <= key[31:0];
        i         <= 6'd4;
        rcon      <= 8'h01;
        key_ready <= 1'b0;
      end else if (state == EXPAND) begin
        w[i] <= w[i - 6'd4] ^ t;
        i    <= i + 6'd1;
        if (i[1:0] == 2'b00) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (last) key_ready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed vector and sequence checks of the AES-128 key expander
module tb_aes_key_expander;
  logic         clk = 0, rst_n = 1, start = 0;
  logic [127:0] key = '0;
  logic         busy, done, key_ready;
  logic [3:0]   rd_round = '0;
  logic [127:0] rd_key;
  int total = 0, bad = 0;
  localparam logic [127:0] FK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] F1   = 128'ha0fafe1788542cb123a339392a6c7605;
  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
    logic [127:0] exp;
  } vec_t;
  vec_t v[10];
  always #5 clk = ~clk;
  aes_key_expander dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key),
    .busy(busy), .done(done), .key_ready(key_ready),
    .rd_round(rd_round), .rd_key(rd_key)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic rd(input logic [3:0] r, output logic [127:0] val);
    rd_round = r;
    #1 val = rd_key;
  endtask
  task automatic launch(input logic [127:0] k);
    @(negedge clk);
    start = 1;
    key = k;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) n = -1;
  endtask
  task automatic chk_cleared(input string nm);
    logic [127:0] val;
    chk({nm, "_busy"}, 128'(busy), 128'd0);
    chk({nm, "_done"}, 128'(done), 128'd0);
    chk({nm, "_key_ready"}, 128'(key_ready), 128'd0);
    for (int r = 0; r < 16; r++) begin
      rd(4'(r), val);
      chk($sformatf("%s_rd%0d", nm, r), val, 128'h0);
    end
  endtask
  initial begin
    logic [127:0] cur, val;
    logic have;
    int n, pulses, at, act;
    v[0] = '{FK, 4'd0, FK};
    v[1] = '{FK, 4'd1, F1};
    v[2] = '{FK, 4'd2, 128'hf2c295f27a96b9435935807a7359f67f};
    v[3] = '{FK, 4'd9, 128'hac7766f319fadc2128d12941575c006e};
    v[4] = '{FK, 4'd10, F10};
    v[5] = '{128'h0, 4'd0, 128'h0};
    v[6] = '{128'h0, 4'd1, Z1};
    v[7] = '{128'h0, 4'd2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    v[8] = '{128'h0, 4'd9, 128'hb1d4d8e28a7db9da1d7bb3de4c664941};
    v[9] = '{128'h0, 4'd10, Z10};
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 128'({busy, done, key_ready}), 128'd0);
    have = 0;
    cur = '0;
    for (int j = 0; j < 10; j++) begin
      if (!have || v[j].key !== cur) begin
        launch(v[j].key);
        chk("accept_busy", 128'({busy, key_ready}), 128'b10);
        wait_done(n);
        chk("latency", 128'(n), 128'd40);
        chk("done_flags", 128'({busy, key_ready}), 128'b01);
        @(negedge clk);
        chk("done_one_cycle", 128'(done), 128'd0);
        cur = v[j].key;
        have = 1;
      end
      rd(v[j].rnd, val);
      chk($sformatf("vec%0d_round%0d", j, v[j].rnd), val, v[j].exp);
    end
    launch(FK);
    pulses = 0;
    at = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        at = c;
      end
      start = (c == 4 || c == 19);
      key = 128'h0;
    end
    start = 0;
    chk("ignored_pulses", 128'(pulses), 128'd1);
    chk("ignored_done_at", 128'(at), 128'd40);
    rd(4'd10, val);
    chk("ignored_round10", val, F10);
    launch(FK);
    wait_done(n);
    chk("restart_first_latency", 128'(n), 128'd40);
    start = 1;
    key = 128'h0;
    @(negedge clk);
    start = 0;
    chk("restart_key_ready_drop", 128'({busy, key_ready}), 128'b10);
    n = 0;
    do begin
      rd(4'(11 + n % 5), val);
      chk("oor_read", val, 128'h0);
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    chk("restart_latency", 128'(done ? n : -1), 128'd40);
    rd(4'd10, val);
    chk("restart_round10", val, Z10);
    launch(FK);
    repeat (16) @(negedge clk);
    rst_n = 0;
    #1 chk_cleared("midrun");
    repeat (3) @(negedge clk);
    rst_n = 1;
    act = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (done || busy) act++;
    end
    chk("midrun_no_activity", 128'(act), 128'd0);
    launch(FK);
    wait_done(n);
    chk("fresh_latency", 128'(n), 128'd40);
    rd(4'd1, val);
    chk("fresh_round1", val, F1);
    rd(4'd10, val);
    chk("fresh_round10", val, F10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Sequential AES-128 key schedule engine. It loads a 128-bit cipher key and produces words w4..w43 at one word per cycle. Each word uses RotWord, SubWord, round-constant injection and the XOR with w[i-4]. All 11 round keys are held in an internal register file with a combinational read port. It sits upstream of the cipher round datapath, which reads round keys by index.

## Interface
Parameters:
- none (AES-128 only; Nk=4, Nr=10 fixed)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  request expansion of `key`; sampled each rising edge
- key  in  128  cipher key; key[127:96]=w0 … key[31:0]=w3; bits [31:24] of each word are byte 0
- busy  out  1  expansion in progress
- done  out  1  one-cycle pulse when w43 has been written
- key_ready  out  1  level; all 11 round keys valid
- rd_round  in  4  round-key index 0..10
- rd_key  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r=rd_round; combinational

## Operation
- Storage: 44 x 32-bit words. A round-key read concatenates 4 words, with the lowest index in the MSBs.
- States:
  - IDLE: busy=0.
  - EXPAND: busy=1, word counter i runs 4..43.
  - IDLE is re-entered after w43 is written.
- Start acceptance (IDLE and start=1):
  - Write key into w0..w3 at that edge.
  - Set i=4, rcon=8'h01, key_ready=0, busy=1.
- Each EXPAND cycle computes and writes w[i] = w[i-4] ^ t, with t defined as follows:
  - If i%4==0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}.
    - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.
    - SubWord applies the FIPS-197 S-box to each byte. There is one shared 4-byte S-box instance.
    - After use, rcon advances by xtime: rcon = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
    - Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - Otherwise t = w[i-1].
- Termination: when i==43 is written, go to IDLE, set busy=0 and key_ready=1, and assert done for exactly one cycle.
- start while busy=1 is ignored; the current expansion continues unaffected.
- start in IDLE while key_ready=1 restarts expansion with the new key. key_ready drops at the accepting edge.
- rd_round > 10 gives rd_key = 128'h0.
- rd_key always reflects current storage. Contents are guaranteed correct only while key_ready=1. During EXPAND, unwritten words hold their prior values.
- Arithmetic: all operations are XOR or table lookup. No carries, no width growth.

## Timing
- Reset (rst_n=0, immediate):
  - busy=0, done=0, key_ready=0.
  - All storage words = 0, so rd_key=0 for every index.
  - i=0, rcon=8'h01, state=IDLE.
- Reset asserted mid-EXPAND aborts immediately and leaves everything in the reset state. No done pulse is produced.
- Latency:
  - start sampled at edge E0.
  - w4 is written at E1 and w43 at E40.
  - done=1 and key_ready=1 during the cycle after E40, and busy=0 from E40.
  - Start-to-done is 40 cycles.
- Back-to-back: start asserted in the done cycle is accepted, with w0..w3 loaded at that edge. Throughput is one key per 41 cycles.
- rd_key has zero-cycle latency from rd_round and from storage updates.
- done and key_ready are registered outputs; no output is combinational from start.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-run, then release. Required: busy=done=key_ready=0 and rd_key=0 for rd_round=0..15. Deasserting reset alone causes no activity.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c. Required:
  - done exactly 40 cycles after start.
  - round 0 = key.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key. Required:
  - round 1 = 62636363626363636263636362636363.
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - The rcon progression must reach 1b and 36, checked through rounds 9 and 10.
- Start ignored while busy: start the FIPS key, then pulse start with the all-zero key at cycles 5 and 20. Required: a single done pulse at cycle 40 and FIPS round 10 intact.
- Restart and out-of-range read: after the FIPS run completes, start the zero key in the done cycle.
  - key_ready must drop at the accepting edge.
  - After 40 cycles, zero-key round 10 must be present.
  - rd_round=11..15 must return 0 throughout.
- Reset mid-EXPAND: assert rst_n=0 at cycle 17 of a run. Required: outputs clear immediately and no done pulse. A following fresh start produces correct keys 40 cycles later.
